osc_phase_gen: RTL and testbench

//  Per-voice phase generator: owns the phase accumulator and drives the (state, phase) pair consumed by
//  the waveform shapers (pulse, saw, ...). Splits each period at a duty threshold into FRONT/BACK halves
//  and reports position within the current half as a normalized fraction. Sits between note/voice

---
 rtl/osc_phase_gen_pkg.sv | 16 +
 rtl/osc_phase_gen_divider.sv | 70 +++++++
 rtl/osc_phase_gen.sv | 156 +++++++++++++++
 tb/tb_osc_phase_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/osc_phase_gen_pkg.sv
// Shared types for the per-voice oscillator phase path.
//   oscillator_state_t : FRONT/BACK half of the period (also used by the shapers)
//   long_percent_t     : normalized position within the current half
//   ctrl_state_t       : phase generator control FSM encoding
package osc_phase_gen_pkg;
  localparam int OSC_ACC_W   = 32;
  localparam int OSC_DUTY_W  = 8;
  localparam int OSC_PHASE_W = 32;

  typedef enum logic { FRONT = 1'b0, BACK = 1'b1 } oscillator_state_t;
  typedef logic [OSC_PHASE_W-1:0] long_percent_t;

  typedef enum logic [1:0] { S_IDLE, S_LOAD, S_DIVIDE, S_DONE } ctrl_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
endpackage

// File: rtl/osc_phase_gen_divider.sv
// phase_divider: restoring unsigned divider, q = floor(num * 2^Q_W / den).
// Requires num < den, so the quotient always fits in Q_W bits.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_start          load num/den and begin; wins over i_abort on the same edge
//   i_abort          drop the in-flight division (no o_done)
//   i_num, i_den     N_W-bit operands
//   o_done           one-cycle pulse after the last of Q_W iteration edges
//   o_quot           quotient, valid when o_done is high
module phase_divider #(
  parameter int N_W = 33,
  parameter int Q_W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic [N_W-1:0] i_num,
  input  logic [N_W-1:0] i_den,
  output logic           o_done,
  output logic [Q_W-1:0] o_quot
);
  localparam int CNT_W = $clog2(Q_W);

  logic [N_W-1:0]   r_rem, r_den;
  logic [Q_W-1:0]   r_quot;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run, r_done;

  // Partial remainder stays below den, so the shifted value needs one extra bit.
  logic [N_W:0] w_shift, w_diff;
  logic         w_ge;
  assign w_shift = {r_rem, 1'b0};
  assign w_ge    = w_shift >= {1'b0, r_den};
  assign w_diff  = w_shift - {1'b0, r_den};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= i_num;
        r_den  <= i_den;
        r_quot <= '0;
        r_cnt  <= '0;
        r_run  <= 1'b1;
      end else if (i_abort) begin
        r_run <= 1'b0;
      end else if (r_run) begin
        r_rem  <= w_ge ? w_diff[N_W-1:0] : w_shift[N_W-1:0];
        r_quot <= {r_quot[Q_W-2:0], w_ge};
        if (r_cnt == CNT_W'(Q_W-1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_quot;
endmodule

// File: rtl/osc_phase_gen.sv
// osc_phase_gen: per-voice phase accumulator feeding the waveform shapers.
// Each accepted sample tick advances the accumulator, then the period is split
// at the duty threshold and the position inside the current half is divided out
// to a normalized fraction. Result appears PHASE_W+2 cycles after the tick.
// Ports:
//   i_clock, i_reset_l  clock, async active-low reset
//   i_enable            voice active; low clears acc and outputs
//   i_sample_tick       one-cycle strobe per audio sample
//   i_sync              hard restart of the period (beats a same-cycle tick)
//   i_increment         phase step per tick
//   i_duty              duty threshold (top bits of the period)
//   o_state, o_phase    FRONT/BACK half and position within it
//   o_out_valid         one-cycle pulse when state/phase/wrapped update
//   o_wrapped           accumulator carried out on the producing tick
//   o_busy              division in flight
//   o_overrun           one-cycle pulse: tick arrived while busy
// Build option: OSC_PHASE_DITHER_EN adds a 16-bit LFSR whose low nibble is
// added to every accepted step.
module osc_phase_gen
  import osc_phase_gen_pkg::*;
#(
  parameter int ACC_W   = OSC_ACC_W,
  parameter int PHASE_W = $bits(long_percent_t),
  parameter int DUTY_W  = OSC_DUTY_W
) (
  input  logic              i_clock,
  input  logic              i_reset_l,
  input  logic              i_enable,
  input  logic              i_sample_tick,
  input  logic              i_sync,
  input  logic [ACC_W-1:0]  i_increment,
  input  logic [DUTY_W-1:0] i_duty,
  output oscillator_state_t o_state,
  output long_percent_t     o_phase,
  output logic              o_out_valid,
  output logic              o_wrapped,
  output logic              o_busy,
  output logic              o_overrun
);
  ctrl_state_t       r_fsm;
  logic [ACC_W-1:0]  r_acc;
  logic              r_wrap_pend;
  oscillator_state_t r_half_pend;
  oscillator_state_t r_state;
  long_percent_t     r_phase;
  logic              r_out_valid, r_wrapped, r_busy, r_overrun;

  logic [ACC_W-1:0] w_step;
  logic [ACC_W:0]   w_sum;
`ifdef OSC_PHASE_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_fb;
  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_step = i_increment + ACC_W'(r_lfsr[3:0]);
`else
  assign w_step = i_increment;
`endif
  assign w_sum = {1'b0, r_acc} + {1'b0, w_step};

  // Anything that moves acc invalidates the division in progress.
  logic w_accept, w_abort, w_start;
  assign w_accept = i_enable && i_sample_tick && !i_sync;
  assign w_abort  = !i_enable || i_sync || w_accept;
  assign w_start  = (r_fsm == S_LOAD) && !w_abort;

  // Split the period at D; the BACK denominator needs ACC_W+1 bits (2^ACC_W when D=0).
  logic [ACC_W-1:0]  w_thr;
  logic              w_front;
  logic [ACC_W:0]    w_num, w_den;
  logic [PHASE_W-1:0] w_quot;
  logic              w_div_done;
  assign w_thr   = {i_duty, {(ACC_W-DUTY_W){1'b0}}};
  assign w_front = r_acc < w_thr;
  assign w_num   = w_front ? {1'b0, r_acc} : {1'b0, r_acc - w_thr};
  assign w_den   = w_front ? {1'b0, w_thr} : ({1'b1, {ACC_W{1'b0}}} - {1'b0, w_thr});

  phase_divider #(.N_W(ACC_W+1), .Q_W(PHASE_W)) u_div (
    .i_clk   (i_clock),
    .i_rst_n (i_reset_l),
    .i_start (w_start),
    .i_abort (w_abort),
    .i_num   (w_num),
    .i_den   (w_den),
    .o_done  (w_div_done),
    .o_quot  (w_quot)
  );

  always_ff @(posedge i_clock or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_fsm       <= S_IDLE;
      r_acc       <= '0;
      r_wrap_pend <= 1'b0;
      r_half_pend <= FRONT;
      r_state     <= FRONT;
      r_phase     <= '0;
      r_out_valid <= 1'b0;
      r_wrapped   <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef OSC_PHASE_DITHER_EN
      r_lfsr      <= LFSR_SEED;
`endif
    end else begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      if (!i_enable) begin
        r_fsm     <= S_IDLE;
        r_acc     <= '0;
        r_busy    <= 1'b0;
        r_state   <= FRONT;
        r_phase   <= '0;
        r_wrapped <= 1'b0;
      end else if (i_sync) begin
        r_fsm       <= S_LOAD;
        r_acc       <= '0;
        r_wrap_pend <= 1'b0;
        r_busy      <= 1'b0;
      end else if (i_sample_tick) begin
        // Tick during a division: keep pitch, restart on the new acc.
        r_overrun   <= r_busy;
        r_fsm       <= S_LOAD;
        r_acc       <= w_sum[ACC_W-1:0];
        r_wrap_pend <= w_sum[ACC_W];
        r_busy      <= 1'b0;
`ifdef OSC_PHASE_DITHER_EN
        r_lfsr      <= {r_lfsr[14:0], w_fb};
`endif
      end else begin
        case (r_fsm)
          S_LOAD: begin
            r_half_pend <= w_front ? FRONT : BACK;
            r_busy      <= 1'b1;
            r_fsm       <= S_DIVIDE;
          end
          S_DIVIDE: if (w_div_done) begin
            r_state     <= r_half_pend;
            r_phase     <= w_quot;
            r_wrapped   <= r_wrap_pend;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_fsm       <= S_DONE;
          end
          S_DONE:  r_fsm <= S_IDLE;
          default: r_fsm <= S_IDLE;
        endcase
      end
    end
  end

  assign o_state     = r_state;
  assign o_phase     = r_phase;
  assign o_out_valid = r_out_valid;
  assign o_wrapped   = r_wrapped;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_osc_phase_gen.sv
// Directed bench for osc_phase_gen (ACC_W=PHASE_W=32, DUTY_W=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_osc_phase_gen;
  import osc_phase_gen_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0, tick = 1'b0, sync = 1'b0;
  logic [31:0]       inc = '0;
  logic [7:0]        duty = '0;
  oscillator_state_t st;
  long_percent_t     ph;
  logic              ov, wr, busy, orun;
  int                vec = 0, errs = 0;

  always #5 clk = ~clk;

  osc_phase_gen dut (
    .i_clock       (clk),
    .i_reset_l     (rst_n),
    .i_enable      (en),
    .i_sample_tick (tick),
    .i_sync        (sync),
    .i_increment   (inc),
    .i_duty        (duty),
    .o_state       (st),
    .o_phase       (ph),
    .o_out_valid   (ov),
    .o_wrapped     (wr),
    .o_busy        (busy),
    .o_overrun     (orun)
  );

  // Stimulus helpers (no checking inside).
  task automatic pulse_tick;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  // Cycles from the tick edge to out_valid; -1 if it never came.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ov) begin lat = n; break; end
    end
  endtask

  task automatic clear_acc;
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
  endtask

  task automatic test_reset;
    int cnt;
    #2 rst_n = 1'b0;
    #1;
    vec++; if (st !== FRONT || ph !== 32'h0) begin errs++; $display("FAIL reset_out st=%0d ph=%h want FRONT/0", st, ph); end
    vec++; if ({ov, wr, busy, orun} !== 4'b0) begin errs++; $display("FAIL reset_flags got %b want 0000", {ov, wr, busy, orun}); end
    @(negedge clk); rst_n = 1'b1; en = 1'b1; duty = 8'd128; inc = 32'h2000_0000;
    pulse_tick();
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vec++; if (st !== FRONT || ph !== 32'h0 || {ov, busy, orun} !== 3'b0) begin
      errs++; $display("FAIL reset_mid st=%0d ph=%h flags=%b want FRONT/0/000", st, ph, {ov, busy, orun}); end
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin @(negedge clk); if (ov) cnt++; end
    vec++; if (cnt !== 0) begin errs++; $display("FAIL reset_late_valid got %0d want 0", cnt); end
  endtask

  task automatic test_pulse_duty;
    logic [31:0]       eph [8] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0,
                                   32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
    oscillator_state_t est [8] = '{FRONT, FRONT, FRONT, BACK, BACK, BACK, BACK, FRONT};
    int lat;
    duty = 8'd128; inc = 32'h2000_0000;
    for (int k = 0; k < 8; k++) begin
      pulse_tick();
      wait_valid(lat);
      vec++; if (lat !== 34) begin errs++; $display("FAIL pulse_lat[%0d] got %0d want 34", k, lat); end
      vec++; if (st !== est[k] || ph !== eph[k]) begin
        errs++; $display("FAIL pulse_res[%0d] got %0d/%h want %0d/%h", k, st, ph, est[k], eph[k]); end
      vec++; if (wr !== (k == 7)) begin errs++; $display("FAIL pulse_wrap[%0d] got %b want %b", k, wr, k == 7); end
      @(negedge clk);
      vec++; if (ov !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL pulse_1cyc[%0d] ov=%b busy=%b want 0/0", k, ov, busy); end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_duty_zero;
    logic [31:0] eph [4] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
    int lat;
    clear_acc();
    duty = 8'd0; inc = 32'h4000_0000;
    for (int k = 0; k < 4; k++) begin
      pulse_tick();
      wait_valid(lat);
      vec++; if (lat !== 34 || st !== BACK || ph !== eph[k] || wr !== (k == 3)) begin
        errs++; $display("FAIL duty0[%0d] lat=%0d st=%0d ph=%h wr=%b want 34/BACK/%h/%b", k, lat, st, ph, wr, eph[k], k == 3); end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_sync;
    int lat;
    clear_acc();
    duty = 8'd128; inc = 32'h2000_0000;
    for (int k = 0; k < 3; k++) begin pulse_tick(); wait_valid(lat); repeat (5) @(negedge clk); end
    vec++; if (st !== FRONT || ph !== 32'hC000_0000) begin errs++; $display("FAIL sync_pre got %0d/%h want FRONT/c0000000", st, ph); end
    @(negedge clk); tick = 1'b1; sync = 1'b1;
    @(negedge clk); tick = 1'b0; sync = 1'b0;
    vec++; if (orun !== 1'b0) begin errs++; $display("FAIL sync_overrun got %b want 0", orun); end
    wait_valid(lat);
    vec++; if (lat !== 34 || st !== FRONT || ph !== 32'h0 || wr !== 1'b0) begin
      errs++; $display("FAIL sync_res lat=%0d st=%0d ph=%h wr=%b want 34/FRONT/0/0", lat, st, ph, wr); end
    repeat (5) @(negedge clk);
    pulse_tick(); wait_valid(lat);
    vec++; if (st !== FRONT || ph !== 32'h4000_0000) begin errs++; $display("FAIL sync_after got %0d/%h want FRONT/40000000", st, ph); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_overrun;
    int cnt;
    oscillator_state_t s_seen;
    logic [31:0] p_seen;
    clear_acc();
    duty = 8'd128; inc = 32'h1000_0000;
    s_seen = BACK; p_seen = '0;
    pulse_tick();
    repeat (8) @(negedge clk);
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL ovr_busy got %b want 1", busy); end
    pulse_tick();
    vec++; if (orun !== 1'b1) begin errs++; $display("FAIL ovr_pulse got %b want 1", orun); end
    cnt = 0;
    repeat (45) begin
      @(negedge clk);
      if (ov) begin cnt++; s_seen = st; p_seen = ph; end
    end
    vec++; if (cnt !== 1) begin errs++; $display("FAIL ovr_count got %0d want 1", cnt); end
    vec++; if (s_seen !== FRONT || p_seen !== 32'h4000_0000) begin
      errs++; $display("FAIL ovr_res got %0d/%h want FRONT/40000000", s_seen, p_seen); end
  endtask

  task automatic test_enable;
    int cnt, lat;
    clear_acc();
    duty = 8'd128; inc = 32'h2000_0000;
    pulse_tick(); wait_valid(lat); repeat (5) @(negedge clk);
    pulse_tick();
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    vec++; if (busy !== 1'b0 || st !== FRONT || ph !== 32'h0) begin
      errs++; $display("FAIL en_off busy=%b st=%0d ph=%h want 0/FRONT/0", busy, st, ph); end
    cnt = 0;
    pulse_tick();
    repeat (40) begin @(negedge clk); if (ov) cnt++; end
    vec++; if (cnt !== 0) begin errs++; $display("FAIL en_off_valid got %0d want 0", cnt); end
    en = 1'b1;
    pulse_tick(); wait_valid(lat);
    vec++; if (lat !== 34 || st !== FRONT || ph !== 32'h4000_0000) begin
      errs++; $display("FAIL en_restart lat=%0d got %0d/%h want 34/FRONT/40000000", lat, st, ph); end
    repeat (5) @(negedge clk);
  endtask

`ifdef OSC_PHASE_DITHER_EN
  // duty=0 makes phase equal the accumulator, exposing the dithered step.
  task automatic test_dither;
    logic [15:0] lfsr;
    logic [31:0] acc, prev, dev;
    int lat;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; en = 1'b1;
    duty = 8'd0; inc = 32'h1000_0000;
    lfsr = 16'hACE1; acc = '0;
    for (int k = 0; k < 8; k++) begin
      prev = acc;
      acc  = acc + inc + {28'h0, lfsr[3:0]};
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      pulse_tick(); wait_valid(lat);
      dev = ph - prev - inc;
      vec++; if (ph !== acc || dev > 32'd15) begin
        errs++; $display("FAIL dither[%0d] got %h want %h (dev %0d)", k, ph, acc, dev); end
      repeat (5) @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pulse_duty();
    test_duty_zero();
    test_sync();
    test_overrun();
    test_enable();
`ifdef OSC_PHASE_DITHER_EN
    test_dither();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
